// File: rtl/zdpu_cap_pkg.sv
// Shared types and default constants for the OV5640 capture scheduler.
package zdpu_cap_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StCapture,
    StCheck,
    StReq,
    StWaitTx,
    StAbort,
    StFlush
  } cap_state_e;

  localparam int unsigned TimeoutCycDef = 200_000_000;
  localparam logic [31:0] MinBytesDef   = 32'd16;
  localparam int unsigned FlushCycDef   = 8;

endpackage

// File: rtl/zsync_edge.sv
// Two-flop synchronizer for an asynchronous level, with registered rise/fall strobes.
module zsync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic meta_q, sync_q, prev_q, rise_q, fall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
      fall_q <= ~sync_q & prev_q;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/zov5640_cap_sched.sv
// Capture scheduler: VSYNC decimation, frame-done latching, uploader handshake,
// watchdog abort and FIFO flush.
module zov5640_cap_sched
  import zdpu_cap_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TimeoutCycDef,
  parameter logic [31:0] MIN_BYTES   = MinBytesDef,
  parameter int unsigned FLUSH_CYC   = FlushCycDef
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iStart,
  input  logic [3:0]  iSkipN,
  input  logic        iDVP_VSYNC,
  input  logic        iFrmDone,
  input  logic [31:0] iFrmBytes,
  input  logic        iTxAck,
  input  logic        iTxDone,
  output logic        oCapEn,
  output logic        oFifoFlush,
  output logic        oTxReq,
  output logic [31:0] oTxLen,
  output logic        oBusy,
  output logic [15:0] oFrmCnt,
  output logic [15:0] oDropCnt,
  output logic        oTimeout
);

  localparam logic [31:0] WdLoad    = 32'(TIMEOUT_CYC - 1);
  localparam int unsigned FlushW    = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FlushW-1:0] FlushLoad = FlushW'(FLUSH_CYC - 1);

  cap_state_e state_q, state_d;

  logic              vs_rise, done_rise;
  logic              unused_vs_fall, unused_done_fall;
  logic [3:0]        skip_q;
  logic [31:0]       wd_q;
  logic [FlushW-1:0] flush_cnt_q;
  logic [31:0]       tx_len_q;
  logic [15:0]       frm_q, drop_q;
  logic              timeout_q, start_q;
  logic              cap_en_q, flush_q, tx_req_q, busy_q;
  logic              cap_en_d, flush_d, tx_req_d, busy_d;
  logic              short_frm, wd_zero, flush_last;

  zsync_edge u_vsync (
    .clk  (iClk),
    .rst  (iRst),
    .d    (iDVP_VSYNC),
    .rise (vs_rise),
    .fall (unused_vs_fall)
  );

  zsync_edge u_done (
    .clk  (iClk),
    .rst  (iRst),
    .d    (iFrmDone),
    .rise (done_rise),
    .fall (unused_done_fall)
  );

  assign short_frm  = (tx_len_q <= MIN_BYTES);
  assign wd_zero    = (wd_q == '0);
  assign flush_last = (flush_cnt_q == '0);

  always_ff @(posedge iClk) begin
    if (iRst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (iStart) state_d = StSync;
      StSync: begin
        if (!iStart)                        state_d = StIdle;
        else if (vs_rise && skip_q == '0)   state_d = StCapture;
      end
      // A done edge on the expiry cycle still completes the frame.
      StCapture: begin
        if (done_rise)    state_d = StCheck;
        else if (wd_zero) state_d = StAbort;
      end
      StCheck:   state_d = short_frm ? StFlush : StReq;
      StReq:     if (iTxAck) state_d = StWaitTx;
      StWaitTx: begin
        if (iTxDone)      state_d = iStart ? StSync : StIdle;
        else if (wd_zero) state_d = StAbort;
      end
      StAbort:   state_d = StFlush;
      StFlush:   if (flush_last) state_d = iStart ? StSync : StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Outputs decoded from the next state so they land in the same cycle as the state.
  always_comb begin
    cap_en_d = (state_d == StCapture);
    flush_d  = (state_d == StFlush);
    tx_req_d = (state_d == StReq);
    busy_d   = (state_d != StIdle);
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      cap_en_q <= 1'b0;
      flush_q  <= 1'b0;
      tx_req_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      cap_en_q <= cap_en_d;
      flush_q  <= flush_d;
      tx_req_q <= tx_req_d;
      busy_q   <= busy_d;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      skip_q      <= '0;
      wd_q        <= '0;
      flush_cnt_q <= '0;
      tx_len_q    <= '0;
      frm_q       <= '0;
      drop_q      <= '0;
      timeout_q   <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      start_q <= iStart;

      if ((state_q == StIdle && iStart) || (state_q == StWaitTx && iTxDone) ||
          (state_q == StFlush && flush_last)) begin
        skip_q <= iSkipN;
      end else if (state_q == StSync && iStart && vs_rise && skip_q != '0) begin
        skip_q <= skip_q - 4'd1;
      end

      if ((state_q == StSync && state_d == StCapture) ||
          (state_q == StReq && state_d == StWaitTx)) begin
        wd_q <= WdLoad;
      end else if ((state_q == StCapture || state_q == StWaitTx) && !wd_zero) begin
        wd_q <= wd_q - 32'd1;
      end

      if (state_d == StFlush && state_q != StFlush) begin
        flush_cnt_q <= FlushLoad;
      end else if (state_q == StFlush && !flush_last) begin
        flush_cnt_q <= flush_cnt_q - FlushW'(1);
      end

      if (state_q == StCapture && done_rise) tx_len_q <= iFrmBytes;
      else if (state_d == StIdle)            tx_len_q <= '0;

      if (state_q == StWaitTx && iTxDone) frm_q <= frm_q + 16'd1;

      if ((state_q == StAbort || (state_q == StCheck && short_frm)) && drop_q != 16'hFFFF) begin
        drop_q <= drop_q + 16'd1;
      end

      if (state_q == StAbort)       timeout_q <= 1'b1;
      else if (iStart && !start_q)  timeout_q <= 1'b0;
    end
  end

  assign oCapEn     = cap_en_q;
  assign oFifoFlush = flush_q;
  assign oTxReq     = tx_req_q;
  assign oTxLen     = tx_len_q;
  assign oBusy      = busy_q;
  assign oFrmCnt    = frm_q;
  assign oDropCnt   = drop_q;
  assign oTimeout   = timeout_q;

endmodule

// File: tb/tb_zov5640_cap_sched.sv
// Randomized self-checking bench for zov5640_cap_sched with a short watchdog.
module tb_zov5640_cap_sched;

  localparam int unsigned TCyc = 200;
  localparam int unsigned FCyc = 8;
  localparam logic [31:0] MinB = 32'd16;

  logic        clk = 1'b0;
  logic        rst, start, vsync, frm_done, tx_ack, tx_done;
  logic [3:0]  skip_n;
  logic [31:0] frm_bytes;
  logic        cap_en, fifo_flush, tx_req, busy, timeout;
  logic [31:0] tx_len;
  logic [15:0] frm_cnt, drop_cnt;

  int n_vec = 0;
  int n_err = 0;
  int unsigned exp_frm, exp_drop;

  always #5 clk = ~clk;

  zov5640_cap_sched #(
    .TIMEOUT_CYC (TCyc),
    .MIN_BYTES   (MinB),
    .FLUSH_CYC   (FCyc)
  ) dut (
    .iClk       (clk),
    .iRst       (rst),
    .iStart     (start),
    .iSkipN     (skip_n),
    .iDVP_VSYNC (vsync),
    .iFrmDone   (frm_done),
    .iFrmBytes  (frm_bytes),
    .iTxAck     (tx_ack),
    .iTxDone    (tx_done),
    .oCapEn     (cap_en),
    .oFifoFlush (fifo_flush),
    .oTxReq     (tx_req),
    .oTxLen     (tx_len),
    .oBusy      (busy),
    .oFrmCnt    (frm_cnt),
    .oDropCnt   (drop_cnt),
    .oTimeout   (timeout)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hard_reset();
    rst = 1'b1; start = 1'b0; vsync = 1'b0; frm_done = 1'b0;
    tx_ack = 1'b0; tx_done = 1'b0; skip_n = 4'd0; frm_bytes = 32'd0;
    tick(2);
    rst = 1'b0;
    exp_frm = 0;
    exp_drop = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; vsync = 1'b1; frm_done = 1'b1;
    tx_ack = 1'b1; tx_done = 1'b1; skip_n = 4'd5; frm_bytes = 32'hDEAD_BEEF;
    tick(3);
    n_vec++;
    if ({cap_en, fifo_flush, tx_req, busy, timeout, tx_len, frm_cnt, drop_cnt} !== 69'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0",
               {cap_en, fifo_flush, tx_req, busy, timeout, tx_len, frm_cnt, drop_cnt});
    end
    hard_reset();
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL reset_idle_busy: got %b want 0", busy);
    end
  endtask

  // Capture expected on every (skip+1)-th VSYNC edge.
  task automatic test_skip_decimation(input int unsigned skip);
    logic        cap;
    logic [31:0] bytes;
    hard_reset();
    skip_n = 4'(skip);
    start = 1'b1;
    tick(1);
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL skip_busy: got %b want 1", busy);
    end
    for (int e = 1; e <= int'(2 * (skip + 1)); e++) begin
      cap = ((e % (skip + 1)) == 0);
      vsync = 1'b1;
      tick(3);
      n_vec++;
      if (cap_en !== 1'b0) begin
        n_err++; $display("FAIL skip_lat3 edge %0d: got %b want 0", e, cap_en);
      end
      tick(1);
      n_vec++;
      if (cap_en !== cap) begin
        n_err++; $display("FAIL skip_cap edge %0d skip %0d: got %b want %b", e, skip, cap_en, cap);
      end
      vsync = 1'b0;
      if (cap) begin
        bytes = $urandom_range(17, 100000);
        frm_bytes = bytes;
        frm_done = 1'b1;
        tick(4);
        frm_done = 1'b0;
        tick(1);
        n_vec++;
        if (tx_req !== 1'b1 || tx_len !== bytes) begin
          n_err++; $display("FAIL skip_req: got req %b len %0d want 1 %0d", tx_req, tx_len, bytes);
        end
        tx_ack = 1'b1; tick(1); tx_ack = 1'b0;
        tick($urandom_range(1, 5));
        tx_done = 1'b1; tick(1); tx_done = 1'b0;
        exp_frm++;
        n_vec++;
        if (frm_cnt !== 16'(exp_frm)) begin
          n_err++; $display("FAIL skip_frm_cnt: got %0d want %0d", frm_cnt, exp_frm);
        end
      end
      tick(3);
    end
    n_vec++;
    if (frm_cnt !== 16'd2) begin
      n_err++; $display("FAIL skip_total: got %0d want 2", frm_cnt);
    end
  endtask

  // Mixed long and short frames, including the 16/17 byte boundary and ack+done collision.
  task automatic test_random_frames();
    logic [31:0] bytes;
    int          cnt;
    logic        saw_req, both;
    hard_reset();
    start = 1'b1;
    tick(1);
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: bytes = 32'd1040;
        1: bytes = 32'd16;
        2: bytes = 32'd17;
        3: bytes = 32'd0;
        default: bytes = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 32)) : $urandom();
      endcase
      vsync = 1'b1;
      tick(4);
      vsync = 1'b0;
      n_vec++;
      if (cap_en !== 1'b1) begin
        n_err++; $display("FAIL frm_cap_on %0d: got %b want 1", i, cap_en);
      end
      tick($urandom_range(1, 10));
      frm_bytes = bytes;
      frm_done = 1'b1;
      tick(3);
      n_vec++;
      if (cap_en !== 1'b1) begin
        n_err++; $display("FAIL frm_done_lat3 %0d: got %b want 1", i, cap_en);
      end
      tick(1);
      frm_done = 1'b0;
      n_vec++;
      if (cap_en !== 1'b0) begin
        n_err++; $display("FAIL frm_done_lat4 %0d: got %b want 0", i, cap_en);
      end
      tick(1);
      if (bytes > MinB) begin
        n_vec++;
        if (tx_req !== 1'b1 || fifo_flush !== 1'b0 || tx_len !== bytes) begin
          n_err++;
          $display("FAIL frm_req %0d: got req %b flush %b len %0d want 1 0 %0d",
                   i, tx_req, fifo_flush, tx_len, bytes);
        end
        repeat ($urandom_range(1, 6)) begin
          tick(1);
          n_vec++;
          if (tx_req !== 1'b1 || tx_len !== bytes) begin
            n_err++; $display("FAIL frm_hold %0d: got req %b len %0d want 1 %0d", i, tx_req, tx_len, bytes);
          end
        end
        both = ($urandom_range(0, 1) == 1);
        tx_ack = 1'b1;
        tx_done = both;
        tick(1);
        tx_ack = 1'b0;
        tx_done = 1'b0;
        n_vec++;
        if (tx_req !== 1'b0 || frm_cnt !== 16'(exp_frm)) begin
          n_err++;
          $display("FAIL frm_ack %0d: got req %b cnt %0d want 0 %0d", i, tx_req, frm_cnt, exp_frm);
        end
        tick($urandom_range(1, 8));
        tx_done = 1'b1; tick(1); tx_done = 1'b0;
        exp_frm++;
        n_vec++;
        if (frm_cnt !== 16'(exp_frm) || drop_cnt !== 16'(exp_drop)) begin
          n_err++;
          $display("FAIL frm_done_cnt %0d: got %0d/%0d want %0d/%0d", i, frm_cnt, drop_cnt, exp_frm, exp_drop);
        end
      end else begin
        exp_drop++;
        n_vec++;
        if (tx_req !== 1'b0 || fifo_flush !== 1'b1 || drop_cnt !== 16'(exp_drop)) begin
          n_err++;
          $display("FAIL frm_drop %0d: got req %b flush %b drop %0d want 0 1 %0d",
                   i, tx_req, fifo_flush, drop_cnt, exp_drop);
        end
        cnt = 1;
        saw_req = 1'b0;
        for (int k = 0; k < 30; k++) begin
          tick(1);
          saw_req |= tx_req;
          if (fifo_flush) cnt++;
          else break;
        end
        n_vec++;
        if (cnt != int'(FCyc) || saw_req) begin
          n_err++; $display("FAIL frm_flush_len %0d: got %0d req %b want %0d 0", i, cnt, saw_req, FCyc);
        end
        n_vec++;
        if (busy !== 1'b1 || cap_en !== 1'b0) begin
          n_err++; $display("FAIL frm_back_sync %0d: got busy %b cap %b want 1 0", i, busy, cap_en);
        end
      end
    end
    n_vec++;
    if (timeout !== 1'b0) begin
      n_err++; $display("FAIL frm_no_timeout: got %b want 0", timeout);
    end
  endtask

  task automatic test_capture_timeout();
    int cnt;
    hard_reset();
    start = 1'b1;
    tick(1);
    vsync = 1'b1;
    tick(4);
    vsync = 1'b0;
    cnt = 0;
    for (int k = 0; k < int'(TCyc) + 50; k++) begin
      if (cap_en) cnt++;
      else break;
      tick(1);
    end
    n_vec++;
    if (cnt != int'(TCyc)) begin
      n_err++; $display("FAIL to_cap_len: got %0d want %0d", cnt, TCyc);
    end
    n_vec++;
    if (fifo_flush !== 1'b0 || tx_req !== 1'b0 || cap_en !== 1'b0) begin
      n_err++; $display("FAIL to_abort: got flush %b req %b cap %b want 0 0 0", fifo_flush, tx_req, cap_en);
    end
    tick(1);
    n_vec++;
    if (timeout !== 1'b1 || drop_cnt !== 16'd1 || fifo_flush !== 1'b1) begin
      n_err++;
      $display("FAIL to_flag: got to %b drop %0d flush %b want 1 1 1", timeout, drop_cnt, fifo_flush);
    end
    cnt = 1;
    for (int k = 0; k < 30; k++) begin
      tick(1);
      if (fifo_flush) cnt++;
      else break;
    end
    n_vec++;
    if (cnt != int'(FCyc) || busy !== 1'b1) begin
      n_err++; $display("FAIL to_flush: got len %0d busy %b want %0d 1", cnt, busy, FCyc);
    end
    start = 1'b0;
    tick(1);
    n_vec++;
    if (busy !== 1'b0 || timeout !== 1'b1) begin
      n_err++; $display("FAIL to_sticky: got busy %b to %b want 0 1", busy, timeout);
    end
    start = 1'b1;
    tick(1);
    n_vec++;
    if (timeout !== 1'b0 || busy !== 1'b1) begin
      n_err++; $display("FAIL to_clear: got to %b busy %b want 0 1", timeout, busy);
    end
  endtask

  // Done edge lands on the watchdog's last cycle; then WAIT_TX is left to expire.
  task automatic test_done_vs_expiry();
    int n;
    hard_reset();
    start = 1'b1;
    tick(1);
    vsync = 1'b1;
    tick(4);
    vsync = 1'b0;
    tick(int'(TCyc) - 4);
    frm_bytes = 32'd1040;
    frm_done = 1'b1;
    tick(4);
    frm_done = 1'b0;
    n_vec++;
    if (cap_en !== 1'b0 || timeout !== 1'b0) begin
      n_err++; $display("FAIL tie_check: got cap %b to %b want 0 0", cap_en, timeout);
    end
    tick(1);
    n_vec++;
    if (tx_req !== 1'b1 || timeout !== 1'b0 || drop_cnt !== 16'd0 || tx_len !== 32'd1040) begin
      n_err++;
      $display("FAIL tie_req: got req %b to %b drop %0d len %0d want 1 0 0 1040",
               tx_req, timeout, drop_cnt, tx_len);
    end
    tx_ack = 1'b1; tick(1); tx_ack = 1'b0;
    n = 1;
    while (!fifo_flush && n < int'(TCyc) + 50) begin
      tick(1);
      n++;
    end
    n_vec++;
    if (n != int'(TCyc) + 2 || timeout !== 1'b1 || drop_cnt !== 16'd1 || frm_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL tx_wd: got n %0d to %b drop %0d frm %0d want %0d 1 1 0",
               n, timeout, drop_cnt, frm_cnt, TCyc + 2);
    end
  endtask

  task automatic test_rst_and_stop();
    logic bad;
    hard_reset();
    start = 1'b1;
    tick(1);
    vsync = 1'b1; tick(4); vsync = 1'b0;
    frm_bytes = 32'd1040;
    frm_done = 1'b1; tick(4); frm_done = 1'b0;
    tick(1);
    tx_ack = 1'b1; tick(1); tx_ack = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);
    n_vec++;
    if ({cap_en, fifo_flush, tx_req, busy, timeout, tx_len, frm_cnt, drop_cnt} !== 69'd0) begin
      n_err++;
      $display("FAIL rst_wait_tx: got %h want 0",
               {cap_en, fifo_flush, tx_req, busy, timeout, tx_len, frm_cnt, drop_cnt});
    end
    rst = 1'b0;
    start = 1'b0;
    bad = 1'b0;
    repeat (10) begin
      tick(1);
      bad |= fifo_flush | busy;
    end
    n_vec++;
    if (bad !== 1'b0) begin
      n_err++; $display("FAIL rst_no_flush: got %b want 0", bad);
    end
    start = 1'b1;
    tick(3);
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL stop_sync_busy: got %b want 1", busy);
    end
    start = 1'b0;
    tick(1);
    n_vec++;
    if (busy !== 1'b0 || cap_en !== 1'b0) begin
      n_err++; $display("FAIL stop_sync_idle: got busy %b cap %b want 0 0", busy, cap_en);
    end
  endtask

  initial begin
    test_reset();
    test_skip_decimation(2);
    test_skip_decimation($urandom_range(0, 3));
    test_random_frames();
    test_capture_timeout();
    test_done_vs_expiry();
    test_rst_and_stop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
